// File: rtl/filtro_ctrl_seq.sv
// Micro-op sequencer for the shared multiply-add IIR datapath: sample-period counter,
// tick generation and a Moore FSM that issues the mux selects and register enables.
module filtro_ctrl_seq #(
    parameter int CLK_DIV = 10000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       sample_tick,
    output logic       en1,
    output logic       en2,
    output logic       en3,
    output logic       en4,
    output logic       en5,
    output logic       en6,
    output logic       en7,
    output logic [2:0] selmuxS,
    output logic [1:0] selmuxC,
    output logic [2:0] selmuxZ,
    output logic       busy,
    output logic       done
);

    typedef enum logic [3:0] {
        IDLE, SHIFT, I1, W1, I2, W2, I3, W3, I4, W4, I5, W5, DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] count;

    logic [7:1] en_q;
    logic [7:1] n_en;
    logic [2:0] n_s;
    logic [1:0] n_c;
    logic [2:0] n_z;
    logic       n_busy;
    logic       n_done;

    assign sample_tick = run && (count == CNT_W'(CLK_DIV - 1));

    // Ticks outside IDLE are ignored; every other state just walks the schedule.
    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = sample_tick ? SHIFT : IDLE;
            SHIFT:   next_state = I1;
            I1:      next_state = W1;
            W1:      next_state = I2;
            I2:      next_state = W2;
            W2:      next_state = I3;
            I3:      next_state = W3;
            W3:      next_state = I4;
            I4:      next_state = W4;
            W4:      next_state = I5;
            I5:      next_state = W5;
            W5:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decode of the upcoming state, so outputs are registered alongside it.
    // An I/W pair shares selects; only the W half captures the result.
    always_comb begin
        n_en   = '0;
        n_s    = 3'd0;
        n_c    = 2'd0;
        n_z    = 3'd0;
        n_busy = (next_state != IDLE);
        n_done = (next_state == DONE);
        case (next_state)
            SHIFT: begin
                n_en[3] = 1'b1;
                n_en[4] = 1'b1;
            end
            I1, W1: begin n_s = 3'd1; n_c = 2'd0; n_z = 3'd1; end
            I2, W2: begin n_s = 3'd2; n_c = 2'd1; n_z = 3'd2; end
            I3, W3: begin n_s = 3'd1; n_c = 2'd2; n_z = 3'd5; end
            I4, W4: begin n_s = 3'd2; n_c = 2'd3; n_z = 3'd3; end
            I5, W5: begin n_s = 3'd4; n_c = 2'd0; n_z = 3'd4; end
            default: ;
        endcase
        case (next_state)
            W1:      n_en[5] = 1'b1;
            W2:      n_en[2] = 1'b1;
            W3:      n_en[6] = 1'b1;
            W4:      n_en[7] = 1'b1;
            W5:      n_en[1] = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            en_q    <= '0;
            selmuxS <= 3'd0;
            selmuxC <= 2'd0;
            selmuxZ <= 3'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (!run || sample_tick)
                count <= '0;
            else
                count <= count + CNT_W'(1);
            state   <= next_state;
            en_q    <= n_en;
            selmuxS <= n_s;
            selmuxC <= n_c;
            selmuxZ <= n_z;
            busy    <= n_busy;
            done    <= n_done;
        end
    end

    assign en1 = en_q[1];
    assign en2 = en_q[2];
    assign en3 = en_q[3];
    assign en4 = en_q[4];
    assign en5 = en_q[5];
    assign en6 = en_q[6];
    assign en7 = en_q[7];

endmodule

// File: tb/tb_filtro_ctrl_seq.sv
// Self-checking bench: cycle-offset schedule model plus a behavioural Q12 datapath
// closed around the sequencer, compared with the filter's difference equations.
module tb_filtro_ctrl_seq;

    localparam int CLK_DIV = 20;
    localparam int Q       = 12;
    localparam longint NA1 = 2048;
    localparam longint NA2 = -1024;
    localparam longint B1  = -8192;
    localparam longint B2  = 4096;

    logic clk = 1'b0;
    logic reset;
    logic run;
    int   uk;

    logic       sample_tick, en1, en2, en3, en4, en5, en6, en7, busy, done;
    logic [2:0] selmuxS, selmuxZ;
    logic [1:0] selmuxC;
    logic [16:0] act_vec;

    filtro_ctrl_seq #(.CLK_DIV(CLK_DIV), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .sample_tick(sample_tick),
        .en1(en1), .en2(en2), .en3(en3), .en4(en4), .en5(en5), .en6(en6), .en7(en7),
        .selmuxS(selmuxS), .selmuxC(selmuxC), .selmuxZ(selmuxZ),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign act_vec = {en1, en2, en3, en4, en5, en6, en7, selmuxS, selmuxC, selmuxZ, busy, done};

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string tag, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic longint mulq(input longint a, input longint b);
        return (a * b) >>> Q;
    endfunction

    // Micro-op table: operand selects and the enable index captured in the W half.
    int op_s[5]  = '{1, 2, 1, 2, 4};
    int op_c[5]  = '{0, 1, 2, 3, 0};
    int op_z[5]  = '{1, 2, 5, 3, 4};
    int op_en[5] = '{5, 2, 6, 7, 1};

    // p = cycles since the tick (0 = idle, 1 = shift, 2..11 = ops, 12 = done).
    function automatic logic [16:0] expVec(input int p);
        logic [7:1] en;
        int s, c, z, op;
        en = '0; s = 0; c = 0; z = 0;
        if (p == 1) begin
            en[3] = 1'b1;
            en[4] = 1'b1;
        end
        if (p >= 2 && p <= 11) begin
            op = (p - 2) / 2;
            s = op_s[op]; c = op_c[op]; z = op_z[op];
            if ((p - 2) % 2 == 1) en[op_en[op]] = 1'b1;
        end
        return {en[1], en[2], en[3], en[4], en[5], en[6], en[7],
                3'(s), 2'(c), 3'(z), 1'(p != 0), 1'(p == 12)};
    endfunction

    int   rc = 0;
    int   ph = 0;
    logic chk_on = 1'b0;
    longint rf1 = 0, rf2 = 0, u_lat = 0;
    longint ys[$];
    int   dones = 0;

    // Reference timing: run-cycle count modulo the period and phase within a sequence.
    always @(posedge clk) begin
        logic tk;
        tk = run && (rc == CLK_DIV - 1);
        if (!reset) begin
            rc = 0; ph = 0; rf1 = 0; rf2 = 0;
        end else begin
            if (ph > 0) ph = (ph == 12) ? 0 : ph + 1;
            else if (tk) ph = 1;
            rc = run ? ((rc == CLK_DIV - 1) ? 0 : rc + 1) : 0;
        end
    end

    longint fk, fk1, fk2, yk, acc1, acc2, acc3, res;

    function automatic longint sVal(input logic [2:0] s);
        case (s)
            3'd0: return fk;
            3'd1: return fk1;
            3'd2: return fk2;
            3'd3: return longint'(uk);
            default: return 0;
        endcase
    endfunction

    function automatic longint cVal(input logic [1:0] c);
        case (c)
            2'd0: return NA1;
            2'd1: return NA2;
            2'd2: return B1;
            default: return B2;
        endcase
    endfunction

    function automatic longint zVal(input logic [2:0] z);
        case (z)
            3'd1: return longint'(uk);
            3'd2: return acc1;
            3'd3: return acc2;
            3'd4: return acc3;
            3'd5: return fk;
            default: return 0;
        endcase
    endfunction

    // Behavioural datapath with a registered multiply-add unit.
    always @(posedge clk) begin
        if (!reset) begin
            fk <= 0; fk1 <= 0; fk2 <= 0; yk <= 0; acc1 <= 0; acc2 <= 0; acc3 <= 0; res <= 0;
        end else begin
            res <= mulq(sVal(selmuxS), cVal(selmuxC)) + zVal(selmuxZ);
            if (en1) yk <= res;
            if (en2) fk <= res;
            if (en3) fk1 <= fk;
            if (en4) fk2 <= fk1;
            if (en5) acc1 <= res;
            if (en6) acc2 <= res;
            if (en7) acc3 <= res;
        end
    end

    always @(negedge clk) begin
        longint f, y;
        if (chk_on) begin
            checkOutput("tick", sample_tick, run && (rc == CLK_DIV - 1));
            checkOutput("ctl", act_vec, expVec(ph));
            checkOutput("onehot", $countones({en1, en2, en5, en6, en7}) <= 1, 1);
            if (ph == 2) u_lat = uk;
            if (ph == 12) begin
                f = u_lat + mulq(rf1, NA1) + mulq(rf2, NA2);
                y = f + mulq(rf1, B1) + mulq(rf2, B2);
                rf2 = rf1;
                rf1 = f;
                checkOutput("yk", yk, y);
                ys.push_back(yk);
                dones++;
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic rn, input int u, input int n);
        reset = r;
        run   = rn;
        uk    = u;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // which: 0 = sample_tick, 1 = done. n = cycles advanced, b = busy cycles seen.
    task automatic waitSig(input int which, output int n, output int b);
        n = 0;
        b = 0;
        while (((which == 0) ? sample_tick : done) !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) b++;
        end
        if (n >= 200) checkOutput((which == 0) ? "tick_timeout" : "done_timeout", 0, 1);
    endtask

    initial begin
        int n, b, cnt, cyc, start, u;
        logic r, rn;
        reset = 1'b0;
        run   = 1'b1;
        uk    = 4096;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        applyStimulus(1'b0, 1'b1, 4096, 2);
        checkOutput("reset_outputs", act_vec, 0);

        // Impulse response, first tick timing, single-sequence timing.
        applyStimulus(1'b1, 1'b1, 4096, 0);
        waitSig(0, n, b);
        checkOutput("first_tick", n, CLK_DIV - 1);
        waitSig(1, n, b);
        checkOutput("done_lat", n, 12);
        checkOutput("busy_len", b, 12);
        applyStimulus(1'b1, 1'b1, 0, 0);
        repeat (7) begin
            waitSig(0, n, b);
            checkOutput("tick_period", n, CLK_DIV - 12);
            waitSig(1, n, b);
        end
        applyStimulus(1'b1, 1'b1, 0, 1);
        checkOutput("impulse_samples", ys.size(), 8);
        if (ys.size() >= 2) begin
            checkOutput("y0", ys[0], 4096);
            checkOutput("y1", ys[1], -6144);
        end

        // run dropped at I3: sequence finishes, no ticks, restart after a full period.
        waitSig(0, n, b);
        applyStimulus(1'b1, 1'b1, 0, 6);
        applyStimulus(1'b1, 1'b0, 0, 0);
        waitSig(1, n, b);
        checkOutput("runlow_done", n, 6);
        applyStimulus(1'b1, 1'b0, 0, 40);
        applyStimulus(1'b1, 1'b1, 0, 0);
        waitSig(0, n, b);
        checkOutput("restart_tick", n, CLK_DIV - 1);

        // Reset in W2 aborts the sample.
        applyStimulus(1'b1, 1'b1, 0, 5);
        checkOutput("w2_en2", en2, 1);
        applyStimulus(1'b0, 1'b1, 0, 1);
        checkOutput("abort_ctl", act_vec, 0);
        applyStimulus(1'b1, 1'b1, 0, 0);
        cnt = 0;
        repeat (15) begin
            if (en1 || done) cnt++;
            applyStimulus(1'b1, 1'b1, 0, 1);
        end
        checkOutput("abort_no_done", cnt, 0);

        // Randomized run/uk/reset traffic over many samples.
        cyc   = 0;
        start = dones;
        u     = 0;
        rn    = 1'b1;
        while (dones - start < 1000 && cyc < 45000) begin
            r = ($urandom_range(0, 2999) == 0) ? 1'b0 : 1'b1;
            if (run) rn = ($urandom_range(0, 399) != 0);
            else     rn = ($urandom_range(0, 9) == 0);
            if (ph != 1 && ph != 2 && $urandom_range(0, 3) == 0)
                u = int'($urandom_range(0, 8192)) - 4096;
            applyStimulus(r, rn, u, 1);
            cyc++;
        end
        checkOutput("rand_samples", (dones - start) >= 1000, 1);

        applyStimulus(1'b1, 1'b1, 0, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
